// File: rtl/hex_scan_scheduler.sv
// ---------------------------------------------------------------------------
// hex_scan_scheduler
//
// One external two's-complement-to-7-segment decoder is shared among
// N_DIGITS signed nibbles. A load request takes a snapshot of the nibbles.
// Each nibble is then presented on o_dec_bin for SETTLE cycles. The
// decoder's answer is captured into per-digit segment and sign registers,
// and those registers drive the HEX displays.
//
// Handshake: i_load is a level sampled on every rising edge.
//   - In IDLE, i_load starts a sweep.
//   - While o_busy is high, i_load records a single pending request. Several
//     loads collapse into one request.
//   - o_done is high for exactly one cycle at the end of each sweep.
//   - A pending request, or a load arriving in that same o_done cycle,
//     restarts a sweep immediately. The restart samples i_values in the
//     o_done cycle.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_reset      synchronous, active-high reset
//   i_load       snapshot request
//   i_values     packed signed nibbles, digit k = i_values[4k+3:4k]
//   o_busy       high in DRIVE, CAPTURE and DONE
//   o_done       one-cycle completion pulse
//   o_dec_bin    nibble presented to the shared decoder (registered)
//   i_dec_segs   active-low segments from the decoder
//   i_dec_neg    sign flag from the decoder
//   o_hex_out    registered segments, digit k = o_hex_out[7k+6:7k]
//   o_neg_out    registered sign per digit
//   o_dbg_state  current FSM state (IDLE=0, DRIVE=1, CAPTURE=2, DONE=3)
// ---------------------------------------------------------------------------
module hex_scan_scheduler #(
    parameter int N_DIGITS = 3,
    parameter int SETTLE   = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_load,
    input  logic [4*N_DIGITS-1:0] i_values,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [3:0]            o_dec_bin,
    input  logic [6:0]            i_dec_segs,
    input  logic                  i_dec_neg,
    output logic [7*N_DIGITS-1:0] o_hex_out,
    output logic [N_DIGITS-1:0]   o_neg_out,
    output logic [1:0]            o_dbg_state
);

    localparam int              IDX_W       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_DIGITS - 1);
    localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DRIVE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [4*N_DIGITS-1:0]   r_snap;
    logic [IDX_W-1:0]        r_idx;
    logic [3:0]              r_cnt;
    logic                    r_pending;
    logic [3:0]              r_dec_bin;
    logic [7*N_DIGITS-1:0]   r_hex;
    logic [N_DIGITS-1:0]     r_neg;

    logic                    w_busy;
    logic                    w_done;
    logic                    w_start;    // take a snapshot and begin at digit 0
    logic                    w_advance;  // move on to the next digit after a capture
    logic                    w_capture;  // store the decoder result for digit r_idx

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and control strobes
    always_comb begin
        w_next    = r_state;
        w_busy    = 1'b0;
        w_done    = 1'b0;
        w_start   = 1'b0;
        w_advance = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_load) begin
                    w_start = 1'b1;
                    w_next  = S_DRIVE;
                end
            end
            S_DRIVE: begin
                w_busy = 1'b1;
                // r_cnt counts completed DRIVE cycles for this digit, so the
                // last DRIVE cycle is the one where it equals SETTLE-1.
                if (r_cnt == SETTLE_LAST) begin
                    w_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                w_busy    = 1'b1;
                w_capture = 1'b1;
                if (r_idx == LAST_IDX) begin
                    w_next = S_DONE;
                end else begin
                    w_advance = 1'b1;
                    w_next    = S_DRIVE;
                end
            end
            S_DONE: begin
                w_busy = 1'b1;
                w_done = 1'b1;
                // A load in this very cycle is treated like a pending request.
                if (r_pending || i_load) begin
                    w_start = 1'b1;
                    w_next  = S_DRIVE;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: snapshot, digit index, settle counter, result registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_snap    <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_dec_bin <= '0;
            r_hex     <= '1;
            r_neg     <= '0;
        end else begin
            if (w_start) begin
                r_snap    <= i_values;
                r_idx     <= '0;
                r_cnt     <= '0;
                // Loaded together with the snapshot, so the first DRIVE cycle
                // already presents digit 0 to the decoder.
                r_dec_bin <= i_values[3:0];
            end else if (w_advance) begin
                r_idx     <= r_idx + 1'b1;
                r_cnt     <= '0;
                r_dec_bin <= r_snap[(r_idx + 1) * 4 +: 4];
            end else if (r_state == S_DRIVE) begin
                r_cnt <= r_cnt + 4'd1;
            end

            if (w_capture) begin
                r_hex[r_idx * 7 +: 7] <= i_dec_segs;
                r_neg[r_idx]          <= i_dec_neg;
            end

            // The DONE cycle either consumes the request or has none left.
            if (r_state == S_DONE) begin
                r_pending <= 1'b0;
            end else if (i_load && w_busy) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign o_busy      = w_busy;
    assign o_done      = w_done;
    assign o_dec_bin   = r_dec_bin;
    assign o_hex_out   = r_hex;
    assign o_neg_out   = r_neg;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_hex_scan_scheduler.sv
// Bench for hex_scan_scheduler. Two instances are used:
//   u_dut  : N_DIGITS=3, SETTLE=2
//   u_dut1 : N_DIGITS=1, SETTLE=1
// A stand-in decoder table answers o_dec_bin combinationally. Cycle 0 is the
// cycle in which load is high.
module tb_hex_scan_scheduler;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        load;
  logic [11:0] values;
  logic        busy, done;
  logic [3:0]  dec_bin;
  logic [6:0]  dec_segs;
  logic        dec_neg;
  logic [20:0] hex_out;
  logic [2:0]  neg_out;
  logic [1:0]  dbg_state;

  logic        load1;
  logic [3:0]  values1;
  logic        busy1, done1;
  logic [3:0]  dec_bin1;
  logic [6:0]  dec_segs1;
  logic        dec_neg1;
  logic [6:0]  hex_out1;
  logic [0:0]  neg_out1;
  logic [1:0]  dbg_state1;

  int n_checks = 0;
  int n_fail   = 0;
  int rel      = 0;
  bit started  = 1'b0;

  // scoreboards: {hex, neg, done_cycle[7:0]}
  logic [31:0] exp_q[$];
  logic [15:0] exp1_q[$];

  // Stand-in for the lab decoder: active-low gfedcba segments. Entries for
  // 0, 7, -1 and -8 are the responses the lab decoder gives for those inputs.
  function automatic logic [6:0] dec_model(input logic [3:0] v);
    case (v)
      4'h0: dec_model = 7'b1000000;
      4'h1: dec_model = 7'b1111001;
      4'h2: dec_model = 7'b0100100;
      4'h3: dec_model = 7'b0110000;
      4'h4: dec_model = 7'b0011001;
      4'h5: dec_model = 7'b0010010;
      4'h6: dec_model = 7'b0000010;
      4'h7: dec_model = 7'b1111000;
      4'h8: dec_model = 7'b0000000;
      4'h9: dec_model = 7'b1111000;
      4'hA: dec_model = 7'b0000010;
      4'hB: dec_model = 7'b0010010;
      4'hC: dec_model = 7'b0011001;
      4'hD: dec_model = 7'b0110000;
      4'hE: dec_model = 7'b0100100;
      default: dec_model = 7'b1111000;
    endcase
  endfunction

  assign dec_segs  = dec_model(dec_bin);
  assign dec_neg   = dec_bin[3];
  assign dec_segs1 = dec_model(dec_bin1);
  assign dec_neg1  = dec_bin1[3];

  hex_scan_scheduler #(.N_DIGITS(3), .SETTLE(2)) u_dut (
    .i_clk(clk), .i_reset(reset), .i_load(load), .i_values(values),
    .o_busy(busy), .o_done(done), .o_dec_bin(dec_bin),
    .i_dec_segs(dec_segs), .i_dec_neg(dec_neg),
    .o_hex_out(hex_out), .o_neg_out(neg_out), .o_dbg_state(dbg_state)
  );

  hex_scan_scheduler #(.N_DIGITS(1), .SETTLE(1)) u_dut1 (
    .i_clk(clk), .i_reset(reset), .i_load(load1), .i_values(values1),
    .o_busy(busy1), .o_done(done1), .o_dec_bin(dec_bin1),
    .i_dec_segs(dec_segs1), .i_dec_neg(dec_neg1),
    .o_hex_out(hex_out1), .o_neg_out(neg_out1), .o_dbg_state(dbg_state1)
  );

  // ---------------- driver / check tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge; inputs set afterwards apply to cycle rel
  task automatic tick();
    @(posedge clk);
    #1;
    rel = rel + 1;
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    logic [31:0] e;
    if (started && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(rel), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("sweep_result", {8'h0, hex_out, neg_out}, {8'h0, e[31:8]});
        check("done_cycle", 32'(rel), {24'h0, e[7:0]});
      end
    end
  end

  always @(negedge clk) begin
    logic [15:0] e;
    if (started && done1 === 1'b1) begin
      if (exp1_q.size() == 0) begin
        check("unexpected_done1", 32'(rel), 32'hFFFF_FFFF);
      end else begin
        e = exp1_q.pop_front();
        check("n1_result", {24'h0, hex_out1, neg_out1}, {24'h0, e[15:8]});
        check("n1_done_cycle", 32'(rel), {24'h0, e[7:0]});
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [3:0] v;
    reset   = 1'b1;
    load    = 1'b0;
    values  = '0;
    load1   = 1'b0;
    values1 = '0;
    repeat (3) @(posedge clk);
    #1;
    reset   = 1'b0;
    started = 1'b1;

    // reset state, then idle
    @(negedge clk);
    check("rst_hex", {11'h0, hex_out}, 32'h001F_FFFF);
    check("rst_neg", {29'h0, neg_out}, 32'h0);
    check("rst_dec_bin", {28'h0, dec_bin}, 32'h0);
    check("rst_state", {30'h0, dbg_state}, 32'h0);
    check("rst_hex1", {25'h0, hex_out1, neg_out1}, 32'hFE);
    for (int c = 0; c < 5; c++) begin
      tick();
      @(negedge clk);
      check("idle_busy", {31'h0, busy}, 32'h0);
      check("idle_done", {31'h0, done}, 32'h0);
    end

    // sweep 1 {F,7,0}, pending load in cycle 4, restart samples cycle 10 values
    tick();
    rel    = 0;
    load   = 1'b1;
    values = {4'hF, 4'h7, 4'h0};
    exp_q.push_back({7'b1111000, 7'b1111000, 7'b1000000, 3'b100, 8'd10});
    exp_q.push_back({dec_model(4'h8), dec_model(4'h3), dec_model(4'h5), 3'b100, 8'd20});
    for (int c = 1; c <= 23; c++) begin
      tick();
      load   = (c == 4);
      values = (c == 10) ? 12'h835 : 12'($urandom_range(0, 4095));
      @(negedge clk);
      case (c)
        1:  begin
              check("busy_c1", {31'h0, busy}, 32'h1);
              check("dec_bin_c1", {28'h0, dec_bin}, 32'h0);
            end
        3:  check("dec_bin_c3", {28'h0, dec_bin}, 32'h0);
        4:  check("dec_bin_c4", {28'h0, dec_bin}, 32'h7);
        6:  check("dec_bin_c6", {28'h0, dec_bin}, 32'h7);
        7:  check("dec_bin_c7", {28'h0, dec_bin}, 32'hF);
        9:  check("dec_bin_c9", {28'h0, dec_bin}, 32'hF);
        11: begin
              check("busy_c11", {31'h0, busy}, 32'h1);
              check("dec_bin_c11", {28'h0, dec_bin}, 32'h5);
            end
        13: check("dec_bin_c13", {28'h0, dec_bin}, 32'h5);
        14: begin
              check("hold_hex_c14", {11'h0, hex_out},
                    {11'h0, 7'b1111000, 7'b1111000, dec_model(4'h5)});
              check("hold_neg_c14", {29'h0, neg_out}, 32'h4);
            end
        15: check("dec_bin_c15", {28'h0, dec_bin}, 32'h3);
        21: check("busy_c21", {31'h0, busy}, 32'h0);
        23: check("busy_c23", {31'h0, busy}, 32'h0);
        default: ;
      endcase
    end
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    // reset in cycle 6 of a sweep (with a pending load queued in cycle 2)
    tick();
    rel    = 0;
    load   = 1'b1;
    values = 12'($urandom_range(0, 4095));
    for (int c = 1; c <= 6; c++) begin
      tick();
      load  = (c == 2);
      reset = (c == 6);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_hex", {11'h0, hex_out}, 32'h001F_FFFF);
    check("mid_rst_neg", {29'h0, neg_out}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_dec_bin", {28'h0, dec_bin}, 32'h0);
    for (int c = 0; c < 15; c++) begin
      tick();
      @(negedge clk);
      if (c == 14) check("after_rst_busy", {31'h0, busy}, 32'h0);
    end

    // N_DIGITS=1, SETTLE=1: -8, then a random nibble
    tick();
    rel     = 0;
    load1   = 1'b1;
    values1 = 4'h8;
    exp1_q.push_back({7'b0000000, 1'b1, 8'd3});
    for (int c = 1; c <= 5; c++) begin
      tick();
      load1   = 1'b0;
      values1 = 4'($urandom_range(0, 15));
      @(negedge clk);
      if (c == 1) check("n1_busy_c1", {31'h0, busy1}, 32'h1);
      if (c == 4) check("n1_busy_c4", {31'h0, busy1}, 32'h0);
    end
    v = 4'($urandom_range(0, 15));
    tick();
    rel     = 0;
    load1   = 1'b1;
    values1 = v;
    exp1_q.push_back({dec_model(v), v[3], 8'd3});
    for (int c = 1; c <= 5; c++) begin
      tick();
      load1   = 1'b0;
      values1 = ~v;
    end
    check("n1_queue_drained", 32'(exp1_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
